// File: rtl/arb_pkg.sv
// Shared types and constants for the SRAM/UART bus arbiter.
//   - arb_state_e : arbiter FSM states
//   - acc_kind_e  : kind of access latched when leaving IDLE
//   - default UART register addresses and status-word bit positions
package arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSrd,
    StSwrSetup,
    StSwrPulse,
    StUrd,
    StUwr,
    StUwait,
    StDone
  } arb_state_e;

  typedef enum logic [2:0] {
    AccSramRd,
    AccSramWr,
    AccUartRd,
    AccUartWr,
    AccStatRd,
    AccNop
  } acc_kind_e;

  localparam logic [15:0] UartDataAddrDefault = 16'hBF00;
  localparam logic [15:0] UartStatAddrDefault = 16'hBF01;

  // Status word layout: bit0 transmitter ready, bit1 receive data ready.
  localparam int unsigned StatTxReadyBit = 0;
  localparam int unsigned StatRxReadyBit = 1;

endpackage

// File: rtl/sram_uart_arbiter_if.sv
// Bundle of the fetch port, data port and external SRAM/UART bus signals.
//   slave  : arbiter view (takes requests and bus inputs, drives readies and strobes)
//   master : pipeline / board view (drives requests and bus inputs)
interface sram_uart_arbiter_if;
  // Fetch port
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_ready;
  // Data port
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        mem_conflict;
  // External bus
  logic [17:0] bus_addr;
  logic [15:0] bus_dout;
  logic        bus_drive;
  logic [15:0] bus_din;
  logic        sram_en_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic        uart_rdn;
  logic        uart_wrn;
  logic        data_ready;
  logic        tbre;
  logic        tsre;

  modport slave (
    input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata,
    input  bus_din, data_ready, tbre, tsre,
    output if_rdata, if_ready, mem_rdata, mem_ready, mem_conflict,
    output bus_addr, bus_dout, bus_drive, sram_en_n, sram_oe_n, sram_we_n,
    output uart_rdn, uart_wrn
  );

  modport master (
    output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata,
    output bus_din, data_ready, tbre, tsre,
    input  if_rdata, if_ready, mem_rdata, mem_ready, mem_conflict,
    input  bus_addr, bus_dout, bus_drive, sram_en_n, sram_oe_n, sram_we_n,
    input  uart_rdn, uart_wrn
  );
endinterface

// File: rtl/uart_seq.sv
// UART strobe sequencer used by the arbiter when ARB_UART_EN is defined.
// Ports:
//   state_i        current arbiter state
//   data_ready_i   UART receive data available
//   tbre_i, tsre_i UART transmit buffer / shift register empty
//   uart_rdn_o     read strobe, low in URD
//   uart_wrn_o     write strobe, low in UWR
//   done_o         UART phase finished: always in URD, in UWAIT once the transmitter is idle
//   status_o       status register word
module uart_seq
  import arb_pkg::*;
(
  input  arb_state_e  state_i,
  input  logic        data_ready_i,
  input  logic        tbre_i,
  input  logic        tsre_i,
  output logic        uart_rdn_o,
  output logic        uart_wrn_o,
  output logic        done_o,
  output logic [15:0] status_o
);

  logic tx_ready;
  assign tx_ready = tbre_i & tsre_i;

  always_comb begin
    uart_rdn_o = 1'b1;
    uart_wrn_o = 1'b1;
    done_o     = 1'b0;
    status_o   = '0;
    status_o[StatTxReadyBit] = tx_ready;
    status_o[StatRxReadyBit] = data_ready_i;
    unique case (state_i)
      StUrd: begin
        // Read is unconditional; software polls status before reading.
        uart_rdn_o = 1'b0;
        done_o     = 1'b1;
      end
      StUwr:   uart_wrn_o = 1'b0;
      StUwait: done_o     = tx_ready;
      default: ;
    endcase
  end

endmodule

// File: rtl/sram_uart_arbiter.sv
// Shares one external SRAM/UART bus between the instruction-fetch port and the
// data (MEM-stage) port. Data requests win unless a fetch is owed from a previous
// data access that completed while the fetch was waiting.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   arb      : sram_uart_arbiter_if.slave (fetch port, data port, external bus)
// Build option: define ARB_UART_EN to compile in UART data/status decoding and the
// uart_seq sequencer; otherwise every address goes to SRAM and the UART strobes idle high.
module sram_uart_arbiter
  import arb_pkg::*;
#(
  parameter logic [15:0] UART_DATA_ADDR = UartDataAddrDefault,
  parameter logic [15:0] UART_STAT_ADDR = UartStatAddrDefault
) (
  input logic                clk,
  input logic                rst,
  sram_uart_arbiter_if.slave arb
);

  arb_state_e  state_q, state_d;
  acc_kind_e   kind_q, kind_d;
  acc_kind_e   mem_kind;
  logic        grant_mem_q, grant_mem_d;
  logic        fetch_owed_q, fetch_owed_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] if_rdata_q, if_rdata_d;
  logic [15:0] mem_rdata_q, mem_rdata_d;
  logic        uart_done;
  logic [15:0] stat_word;
  logic        mem_req;

  assign mem_req = arb.mem_rd | arb.mem_wr;

`ifdef ARB_UART_EN
  logic uart_rdn, uart_wrn;

  uart_seq u_uart_seq (
    .state_i     (state_q),
    .data_ready_i(arb.data_ready),
    .tbre_i      (arb.tbre),
    .tsre_i      (arb.tsre),
    .uart_rdn_o  (uart_rdn),
    .uart_wrn_o  (uart_wrn),
    .done_o      (uart_done),
    .status_o    (stat_word)
  );

  assign arb.uart_rdn = uart_rdn;
  assign arb.uart_wrn = uart_wrn;

  // A simultaneous read and write request is treated as a write.
  always_comb begin
    mem_kind = arb.mem_wr ? AccSramWr : AccSramRd;
    if (arb.mem_addr == UART_DATA_ADDR) begin
      mem_kind = arb.mem_wr ? AccUartWr : AccUartRd;
    end else if (arb.mem_addr == UART_STAT_ADDR) begin
      mem_kind = arb.mem_wr ? AccNop : AccStatRd;
    end
  end
`else
  logic unused_uart;

  assign uart_done    = 1'b0;
  assign stat_word    = '0;
  assign arb.uart_rdn = 1'b1;
  assign arb.uart_wrn = 1'b1;
  assign mem_kind     = arb.mem_wr ? AccSramWr : AccSramRd;
  assign unused_uart  = ^{arb.data_ready, arb.tbre, arb.tsre, UART_DATA_ADDR, UART_STAT_ADDR};
`endif

  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    grant_mem_d  = grant_mem_q;
    fetch_owed_d = fetch_owed_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (mem_req && !(fetch_owed_q && arb.if_req)) begin
          grant_mem_d = 1'b1;
          kind_d      = mem_kind;
          addr_d      = arb.mem_addr;
          wdata_d     = arb.mem_wdata;
          unique case (mem_kind)
            AccSramRd: state_d = StSrd;
            AccSramWr: state_d = StSwrSetup;
            AccUartRd: state_d = StUrd;
            AccUartWr: state_d = StUwr;
            AccStatRd: begin
              mem_rdata_d = stat_word;
              state_d     = StDone;
            end
            default:   state_d = StDone;  // write to status register: no-op
          endcase
        end else if (arb.if_req) begin
          grant_mem_d  = 1'b0;
          kind_d       = AccSramRd;
          addr_d       = arb.if_addr;
          fetch_owed_d = 1'b0;
          state_d      = StSrd;
        end
      end
      StSrd: begin
        if (grant_mem_q) mem_rdata_d = arb.bus_din;
        else             if_rdata_d  = arb.bus_din;
        state_d = StDone;
      end
      StSwrSetup: state_d = StSwrPulse;
      StSwrPulse: state_d = StDone;
      StUrd: begin
        mem_rdata_d = arb.bus_din;
        if (uart_done) state_d = StDone;
      end
      StUwr:   state_d = StUwait;
      StUwait: if (uart_done) state_d = StDone;
      StDone: begin
        // A fetch that waited out a data access gets the next slot.
        if (grant_mem_q && arb.if_req) fetch_owed_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      kind_q       <= AccSramRd;
      grant_mem_q  <= 1'b0;
      fetch_owed_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      grant_mem_q  <= grant_mem_d;
      fetch_owed_q <= fetch_owed_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
    end
  end

  assign arb.if_ready     = (state_q == StDone) && !grant_mem_q;
  assign arb.mem_ready    = (state_q == StDone) && grant_mem_q;
  assign arb.if_rdata     = if_rdata_q;
  assign arb.mem_rdata    = mem_rdata_q;
  assign arb.mem_conflict = mem_req & ~arb.mem_ready;

  assign arb.bus_addr  = {2'b00, addr_q};
  assign arb.bus_dout  = wdata_q;
  // Write data stays driven through DONE so it is held past the rising edge of we_n.
  assign arb.bus_drive = (state_q == StSwrSetup) || (state_q == StSwrPulse) ||
                         (state_q == StUwr) || ((state_q == StDone) && (kind_q == AccSramWr));
  assign arb.sram_en_n = !((state_q == StSrd) || (state_q == StSwrSetup) ||
                           (state_q == StSwrPulse));
  assign arb.sram_oe_n = (state_q != StSrd);
  assign arb.sram_we_n = (state_q != StSwrPulse);

endmodule

// File: tb/tb_sram_uart_arbiter.sv
module tb_sram_uart_arbiter;
  import arb_pkg::*;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  sram_uart_arbiter_if arb ();

  sram_uart_arbiter dut (
    .clk(clk),
    .rst(rst),
    .arb(arb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-cycle strobe counters, sampled on the falling edge.
  int          m_en, m_oe, m_we, m_drv, m_urd, m_uwr, m_viol;
  logic [15:0] m_drv_dout;
  initial begin
    m_en = 0; m_oe = 0; m_we = 0; m_drv = 0; m_urd = 0; m_uwr = 0; m_viol = 0;
    m_drv_dout = '0;
  end
  always @(negedge clk) begin
    if (!arb.sram_en_n) m_en <= m_en + 1;
    if (!arb.sram_oe_n) m_oe <= m_oe + 1;
    if (!arb.sram_we_n) m_we <= m_we + 1;
    if (!arb.uart_rdn)  m_urd <= m_urd + 1;
    if (!arb.uart_wrn)  m_uwr <= m_uwr + 1;
    if (arb.bus_drive) begin
      m_drv      <= m_drv + 1;
      m_drv_dout <= arb.bus_dout;
    end
    if ((arb.bus_drive || !arb.sram_we_n || !arb.uart_wrn) &&
        (!arb.sram_oe_n || !arb.uart_rdn)) m_viol <= m_viol + 1;
  end

  typedef struct {
    string       name;
    logic        is_fetch;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] din;
    logic        drdy;
    logic        tbre;
    logic        tsre;
    int          lat;
    logic        chk_rd;
    logic [15:0] rdata;
    int          en, oe, we, drv, urd, uwr;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input string name, input logic f, input logic rd, input logic wr,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] din, input logic drdy, input logic tbre,
                         input logic tsre, input int lat, input logic chk_rd,
                         input logic [15:0] rdata, input int en, input int oe, input int we,
                         input int drv, input int urd, input int uwr);
    vec_t v;
    v.name = name; v.is_fetch = f; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.din = din; v.drdy = drdy; v.tbre = tbre; v.tsre = tsre; v.lat = lat;
    v.chk_rd = chk_rd; v.rdata = rdata; v.en = en; v.oe = oe; v.we = we; v.drv = drv;
    v.urd = urd; v.uwr = uwr;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic clear_reqs();
    arb.if_req = 1'b0;
    arb.mem_rd = 1'b0;
    arb.mem_wr = 1'b0;
  endtask

  // Waits (bounded) for the ready of one port. Cycle 0 is the cycle the request is
  // first visible in IDLE. Also captures bus_addr in cycle 1 and checks mem_conflict.
  task automatic wait_port(input bit want_mem, input bit exp_conf, input int budget,
                           output int lat, output int conf_err, output int other,
                           output logic [17:0] addr1);
    lat = -1; conf_err = 0; other = 0; addr1 = '0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (c == 1) addr1 = arb.bus_addr;
      if (want_mem ? arb.if_ready : arb.mem_ready) other++;
      if (want_mem ? arb.mem_ready : arb.if_ready) begin
        lat = c;
        if (arb.mem_conflict !== (want_mem ? 1'b0 : exp_conf)) conf_err++;
        break;
      end
      if (arb.mem_conflict !== exp_conf) conf_err++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int s_en, s_oe, s_we, s_drv, s_urd, s_uwr;
    int lat, conf_err, other;
    logic [17:0] a1;
    logic [15:0] rd;
    @(posedge clk);
    #1;
    s_en = m_en; s_oe = m_oe; s_we = m_we; s_drv = m_drv; s_urd = m_urd; s_uwr = m_uwr;
    arb.data_ready = v.drdy;
    arb.tbre       = v.tbre;
    arb.tsre       = v.tsre;
    arb.bus_din    = v.din;
    if (v.is_fetch) begin
      arb.if_req  = 1'b1;
      arb.if_addr = v.addr;
    end else begin
      arb.mem_rd    = v.rd;
      arb.mem_wr    = v.wr;
      arb.mem_addr  = v.addr;
      arb.mem_wdata = v.wdata;
    end
    wait_port(!v.is_fetch, !v.is_fetch, 20, lat, conf_err, other, a1);
    @(posedge clk);
    rd = v.is_fetch ? arb.if_rdata : arb.mem_rdata;
    check($sformatf("%s_latency", v.name), lat, v.lat);
    check($sformatf("%s_other_ready", v.name), other, 0);
    check($sformatf("%s_conflict", v.name), conf_err, 0);
    check($sformatf("%s_bus_addr", v.name), a1, {2'b00, v.addr});
    check($sformatf("%s_en_cycles", v.name), m_en - s_en, v.en);
    check($sformatf("%s_oe_cycles", v.name), m_oe - s_oe, v.oe);
    check($sformatf("%s_we_cycles", v.name), m_we - s_we, v.we);
    check($sformatf("%s_drive_cycles", v.name), m_drv - s_drv, v.drv);
    check($sformatf("%s_uart_rdn_cycles", v.name), m_urd - s_urd, v.urd);
    check($sformatf("%s_uart_wrn_cycles", v.name), m_uwr - s_uwr, v.uwr);
    if (v.chk_rd) check($sformatf("%s_rdata", v.name), rd, v.rdata);
    if (v.drv > 0) check($sformatf("%s_bus_dout", v.name), m_drv_dout, v.wdata);
    #1;
    clear_reqs();
  endtask

  initial begin
    int lat, conf_err, other, found, cnt, s_we, s_uwr;
    logic [17:0] a1;
    n_pass = 0;
    n_total = 0;

    //        name        f rd wr addr      wdata     din  drdy tbre tsre lat chk rdata
    //        en oe we drv urd uwr
    add_vec("fetch",     1, 0, 0, 16'h0010, 16'h0000, 16'h6801, 0, 1, 1, 2, 1, 16'h6801,
            1, 1, 0, 0, 0, 0);
    add_vec("sram_rd",   0, 1, 0, 16'h1234, 16'h0000, 16'hA5A5, 0, 1, 1, 2, 1, 16'hA5A5,
            1, 1, 0, 0, 0, 0);
    add_vec("sram_wr",   0, 0, 1, 16'h8000, 16'hBEEF, 16'h0000, 0, 1, 1, 3, 0, 16'h0000,
            2, 0, 1, 3, 0, 0);
    add_vec("rdwr_both", 0, 1, 1, 16'h0042, 16'h1111, 16'h0000, 0, 1, 1, 3, 0, 16'h0000,
            2, 0, 1, 3, 0, 0);
    add_vec("fetch_bf00", 1, 0, 0, 16'hBF00, 16'h0000, 16'h1357, 0, 1, 1, 2, 1, 16'h1357,
            1, 1, 0, 0, 0, 0);
`ifdef ARB_UART_EN
    add_vec("uart_rd",   0, 1, 0, 16'hBF00, 16'h0000, 16'h0055, 0, 1, 1, 2, 1, 16'h0055,
            0, 0, 0, 0, 1, 0);
    add_vec("stat_wr",   0, 0, 1, 16'hBF01, 16'h7777, 16'h0000, 0, 1, 1, 1, 0, 16'h0000,
            0, 0, 0, 0, 0, 0);
    add_vec("stat_rd3",  0, 1, 0, 16'hBF01, 16'h0000, 16'hFFFF, 1, 1, 1, 1, 1, 16'h0003,
            0, 0, 0, 0, 0, 0);
    add_vec("stat_rd2",  0, 1, 0, 16'hBF01, 16'h0000, 16'hFFFF, 1, 1, 0, 1, 1, 16'h0002,
            0, 0, 0, 0, 0, 0);
    add_vec("stat_rd1",  0, 1, 0, 16'hBF01, 16'h0000, 16'hFFFF, 0, 1, 1, 1, 1, 16'h0001,
            0, 0, 0, 0, 0, 0);
    add_vec("uart_wr",   0, 0, 1, 16'hBF00, 16'h0041, 16'h0000, 0, 1, 1, 3, 0, 16'h0000,
            0, 0, 0, 1, 0, 1);
`else
    add_vec("rd_bf00",   0, 1, 0, 16'hBF00, 16'h0000, 16'h0BF0, 1, 1, 1, 2, 1, 16'h0BF0,
            1, 1, 0, 0, 0, 0);
    add_vec("wr_bf01",   0, 0, 1, 16'hBF01, 16'h7777, 16'h0000, 1, 1, 1, 3, 0, 16'h0000,
            2, 0, 1, 3, 0, 0);
`endif

    // Reset state
    rst = 1'b1;
    clear_reqs();
    arb.if_addr = '0; arb.mem_addr = '0; arb.mem_wdata = '0; arb.bus_din = '0;
    arb.data_ready = 1'b0; arb.tbre = 1'b1; arb.tsre = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_strobes", {arb.sram_en_n, arb.sram_oe_n, arb.sram_we_n, arb.uart_rdn,
                            arb.uart_wrn, arb.bus_drive}, 6'b111110);
    check("reset_readies", {arb.if_ready, arb.mem_ready}, 2'b00);
    check("reset_rdata", {arb.if_rdata, arb.mem_rdata}, 32'h0);
    check("reset_bus_addr", arb.bus_addr, 18'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (vq[i]) run_vec(vq[i]);

    // Collision: write wins, the owed fetch goes next even with a new data read pending.
    @(posedge clk);
    #1;
    s_we = m_we;
    arb.if_req = 1'b1; arb.if_addr = 16'h0020; arb.bus_din = 16'h6801;
    arb.mem_wr = 1'b1; arb.mem_addr = 16'h8000; arb.mem_wdata = 16'hBEEF;
    wait_port(1'b1, 1'b1, 20, lat, conf_err, other, a1);
    check("coll_wr_latency", lat, 3);
    check("coll_wr_no_fetch", other, 0);
    check("coll_wr_conflict", conf_err, 0);
    @(posedge clk);
    check("coll_wr_we_cycles", m_we - s_we, 1);
    #1;
    arb.mem_wr = 1'b0; arb.mem_rd = 1'b1; arb.mem_addr = 16'h1234;
    wait_port(1'b0, 1'b1, 20, lat, conf_err, other, a1);
    check("coll_fetch_latency", lat, 2);
    check("coll_fetch_before_mem", other, 0);
    check("coll_fetch_conflict", conf_err, 0);
    check("coll_fetch_addr", a1, 18'h00020);
    @(posedge clk);
    check("coll_fetch_rdata", arb.if_rdata, 16'h6801);
    #1;
    arb.if_req = 1'b0; arb.bus_din = 16'h2222;
    wait_port(1'b1, 1'b1, 20, lat, conf_err, other, a1);
    check("coll_rd_latency", lat, 2);
    @(posedge clk);
    check("coll_rd_rdata", arb.mem_rdata, 16'h2222);
    #1 clear_reqs();

`ifdef ARB_UART_EN
    // UART write stalled by a busy transmitter for 5 cycles.
    @(posedge clk);
    #1;
    s_uwr = m_uwr;
    arb.tbre = 1'b0; arb.tsre = 1'b0;
    arb.mem_wr = 1'b1; arb.mem_addr = 16'hBF00; arb.mem_wdata = 16'h0041;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (arb.mem_ready) cnt++;
    end
    check("uwait_early_ready", cnt, 0);
    @(posedge clk);
    #1;
    arb.tbre = 1'b1; arb.tsre = 1'b1;
    wait_port(1'b1, 1'b1, 20, lat, conf_err, other, a1);
    check("uwait_ready_after_status", lat, 1);
    @(posedge clk);
    check("uwait_wrn_cycles", m_uwr - s_uwr, 1);
    check("uwait_dout", m_drv_dout, 16'h0041);
    #1 clear_reqs();
`endif

    // Reset asserted while the write strobe is low.
    @(posedge clk);
    #1;
    arb.mem_wr = 1'b1; arb.mem_addr = 16'h0300; arb.mem_wdata = 16'h1357;
    found = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (arb.sram_we_n === 1'b0) begin
        found = 1;
        break;
      end
    end
    check("rst_reached_pulse", found, 1);
    rst = 1'b1;
    arb.mem_wr = 1'b0;
    @(negedge clk);
    check("rst_we_n", arb.sram_we_n, 1'b1);
    check("rst_drive", arb.bus_drive, 1'b0);
    check("rst_en_n", arb.sram_en_n, 1'b1);
    check("rst_state", 32'(dut.state_q), 32'(StIdle));
    check("rst_mem_rdata", arb.mem_rdata, 16'h0);
    check("rst_bus_addr", arb.bus_addr, 18'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (arb.mem_ready || arb.if_ready) cnt++;
    end
    check("rst_no_ready", cnt, 0);

    check("strobe_overlap", m_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
